fifo_token_packer: RTL and testbench
====================================

Name: fifo_token_packer

Overview:
- Sits directly downstream of the project FIFO's read side and upstream of another project FIFO's write side.
- Pops narrow tokens through the `empty_n`/`read`/`dout` handshake and packs RATIO consecutive tokens into one wide word.
- Pushes each packed word into the next FIFO through the `full_n`/`write`/`din` handshake.
- Used between actors whose port widths differ by an integer factor.

Parameters:
- IN_WIDTH, 8, width of one upstream token.
- RATIO, 4, tokens per packed word; must be ≥2 (need not be a power of two).
- OUT_WIDTH, IN_WIDTH*RATIO, derived; must not be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_empty_n  in  1  upstream FIFO holds ≥1 token; in_dout is valid in the same cycle (combinational read).
- in_dout  in  IN_WIDTH  upstream token at the FIFO head.
- in_read  out  1  pops the head token at this rising edge.
- out_full_n  in  1  downstream FIFO has ≥1 free slot.
- out_din  out  OUT_WIDTH  packed word.
- out_write  out  1  writes out_din into the downstream FIFO at this rising edge.
- words_out  out  16  count of packed words written; wraps from 0xFFFF to 0.

Behaviour:
- Registers:
  - acc: OUT_WIDTH accumulator.
  - lane: counter, 0..RATIO-1.
  - ob: OUT_WIDTH output buffer.
  - ob_valid: 1 bit.
  - words_out: 16 bits.
- Reset, asynchronous and immediate: acc=0, lane=0, ob=0, ob_valid=0, words_out=0. in_read and out_write are forced low while rst is high.
- out_write = ob_valid & out_full_n. It is never high while out_full_n=0, because the downstream FIFO RAM writes on write regardless of full.
- out_din = ob at all times.
- drain = out_write.
- in_read = in_empty_n & (lane != RATIO-1 | !ob_valid | drain). It is never high while in_empty_n=0.
- Lane order: the first token of a word goes to bits [IN_WIDTH-1:0]; token k goes to bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- On in_read with lane < RATIO-1:
  - acc lane slice <= in_dout.
  - lane <= lane+1.
- On in_read with lane == RATIO-1:
  - ob <= acc with the top slice replaced by in_dout.
  - ob_valid <= 1.
  - lane <= 0.
  - acc is not cleared; stale slices are overwritten before reuse.
- On drain without a completing in_read: ob_valid <= 0.
- On drain in the same cycle as a completing in_read: ob_valid stays 1 and ob takes the new word. This gives back-to-back words with no bubble.
- words_out increments on every drain.
- Latency: the edge consuming the last token of a word → out_write high in the next cycle, provided out_full_n=1.
- Throughput: 1 token/cycle sustained while out_full_n=1.
- Backpressure:
  - With ob_valid=1 and out_full_n=0, the packer keeps accepting tokens for lanes 0..RATIO-2.
  - It stalls only on the completing token; in_read=0 until a drain occurs.
  - ob holds its value under stall.
- Upstream empty mid-word: lane and acc hold indefinitely; no timeout and no partial output (except under the optional feature).
- Reset mid-word or with ob_valid=1: partial tokens and the pending word are discarded and no write is issued.
- RATIO non-power-of-two: lane wraps at RATIO-1 explicitly, not by overflow.

Optional Feature:
- Macro: FIFO_TOKEN_PACKER_FLUSH_EN.
- When defined:
  - Adds input port `flush` (1 bit).
  - When flush=1 and lane>0, the packer ignores in_empty_n that cycle (in_read=0). On the next free output slot, treated exactly like a completing token, it moves acc to ob with lanes ≥lane zeroed and sets lane <= 0.
  - Flush with lane=0 is a no-op.
  - flush must be held until lane returns to 0; flush while stalled waits for the drain.
- When undefined:
  - No flush port.
  - Partial words stay in acc until completed or until reset.

Test Plan:
1. Reset, then 8 tokens 0x01..0x08 with out_full_n=1 (IN_WIDTH=8, RATIO=4) → exactly 2 writes, out_din 0x04030201 then 0x08070605. Each write occurs 1 cycle after the edge popping its last token. words_out=2.
2. Continuous upstream, out_full_n=1 for 40 cycles → in_read high every cycle, out_write pulses every 4th cycle with no bubbles, words_out=10.
3. out_full_n=0 after the first word completes, 7 tokens available → 3 more tokens accepted, then in_read=0. ob stays 0x04030201 and out_write=0. Raise out_full_n → write 0x04030201, then the 4th token is accepted on the same drain cycle.
4. 2 tokens 0xAA, 0xBB then in_empty_n=0 for 20 cycles → no write and lane=2. Then 0xCC, 0xDD → write 0xDDCCBBAA.
5. Assert rst asynchronously (mid-cycle) with lane=3 and ob_valid=1 → out_write and in_read drop immediately. Next 4 tokens 0x11..0x14 produce 0x14131211.
6. FIFO_TOKEN_PACKER_FLUSH_EN defined: tokens 0x21, 0x22, then flush → write 0x00002221 and lane=0. A flush with lane=0 produces no write.

Source files
------------

// File: rtl/fifo_token_packer.sv
// Packs RATIO narrow tokens popped from an upstream FIFO into one wide word for a downstream FIFO.
// Define FIFO_TOKEN_PACKER_FLUSH_EN to add a flush input that emits a zero-padded partial word.
module fifo_token_packer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4,
   localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
   input  logic                 flush,
`endif
   input  logic                 in_empty_n,
   input  logic [IN_WIDTH-1:0]  in_dout,
   output logic                 in_read,
   input  logic                 out_full_n,
   output logic [OUT_WIDTH-1:0] out_din,
   output logic                 out_write,
   output logic [15:0]          words_out
);

   localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
   localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);

   logic [OUT_WIDTH-1:0] r_acc;
   logic [OUT_WIDTH-1:0] r_ob;
   logic [LANE_W-1:0]    r_lane;
   logic                 r_ob_valid;
   logic [15:0]          r_words_out;

   logic                 w_last;
   logic                 w_drain;
   logic                 w_read;
   logic                 w_flush_act;
   logic                 w_flush_fire;
   logic                 w_complete;
   logic [OUT_WIDTH-1:0] w_ob_next;

   assign w_last  = (r_lane == LANE_LAST);
   // The downstream RAM writes whenever write is high, so full_n must gate it.
   assign w_drain = r_ob_valid & out_full_n & ~rst;

`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
   assign w_flush_act  = flush & (r_lane != '0);
   assign w_flush_fire = w_flush_act & (~r_ob_valid | w_drain) & ~rst;
`else
   assign w_flush_act  = 1'b0;
   assign w_flush_fire = 1'b0;
`endif

   // Only the completing token needs a free output slot; earlier lanes keep filling.
   assign w_read     = in_empty_n & ~w_flush_act & (~w_last | ~r_ob_valid | w_drain) & ~rst;
   assign w_complete = (w_read & w_last) | w_flush_fire;

   always_comb begin
      w_ob_next = r_acc;
      if (w_flush_fire) begin
         for (int k = 0; k < RATIO; k++) begin
            if (k >= int'(r_lane)) begin
               w_ob_next[k*IN_WIDTH +: IN_WIDTH] = '0;
            end
         end
      end else begin
         w_ob_next[OUT_WIDTH-1 -: IN_WIDTH] = in_dout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_lane      <= '0;
         r_ob        <= '0;
         r_ob_valid  <= 1'b0;
         r_words_out <= '0;
      end else begin
         if (w_read & ~w_last) begin
            r_acc[int'(r_lane)*IN_WIDTH +: IN_WIDTH] <= in_dout;
            r_lane <= r_lane + LANE_ONE;
         end
         // A completion on a drain cycle refills ob directly, so words stream without bubbles.
         if (w_complete) begin
            r_ob       <= w_ob_next;
            r_ob_valid <= 1'b1;
            r_lane     <= '0;
         end else if (w_drain) begin
            r_ob_valid <= 1'b0;
         end
         if (w_drain) begin
            r_words_out <= r_words_out + 16'd1;
         end
      end
   end

   assign in_read   = w_read;
   assign out_write = w_drain;
   assign out_din   = r_ob;
   assign words_out = r_words_out;

endmodule

// File: tb/tb_fifo_token_packer.sv
// Randomized scoreboard bench for fifo_token_packer (IN_WIDTH=8, RATIO=4).
module tb_fifo_token_packer;

   localparam int IW = 8;
   localparam int R  = 4;
   localparam int OW = IW * R;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          in_empty_n = 1'b0;
   logic          out_full_n = 1'b0;
   logic [IW-1:0] in_dout    = '0;
   logic          in_read;
   logic          out_write;
   logic [OW-1:0] out_din;
   logic [15:0]   words_out;
`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
   logic          flush      = 1'b0;
`endif

   fifo_token_packer #(
      .IN_WIDTH (IW),
      .RATIO    (R)
   ) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
      .flush      (flush),
`endif
      .in_empty_n (in_empty_n),
      .in_dout    (in_dout),
      .in_read    (in_read),
      .out_full_n (out_full_n),
      .out_din    (out_din),
      .out_write  (out_write),
      .words_out  (words_out)
   );

   always #5 clk = ~clk;

   // Upstream FIFO contents, expected packed words, and the word being assembled.
   logic [IW-1:0] up_q[$];
   logic [OW-1:0] exp_q[$];
   logic [OW-1:0] w_m = '0;
   int            part = 0;
   logic [15:0]   n_wr = '0;
   int            p_avail = 100;
   int            p_full  = 100;
   int            total = 0;
   int            bad   = 0;

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives inputs on the falling edge, then checks the handshake the model predicts.
   initial begin : driver
      logic exp_rd;
      logic exp_wr;
      logic fl_act;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_empty_n = 1'b0;
            out_full_n = 1'b0;
            continue;
         end
         in_empty_n = (up_q.size() > 0) && ($urandom_range(99) < p_avail);
         in_dout    = in_empty_n ? up_q[0] : IW'($urandom);
         out_full_n = ($urandom_range(99) < p_full);
         #1;
         if (rst) continue;
         fl_act = 1'b0;
`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
         fl_act = flush && (part != 0);
`endif
         exp_rd = in_empty_n && !fl_act && (part != R - 1 || exp_q.size() == 0 || out_full_n);
         exp_wr = (exp_q.size() != 0) && out_full_n;
         chk("in_read", in_read, exp_rd);
         chk("out_write", out_write, exp_wr);
         if (in_read && up_q.size() > 0) begin
            w_m[part*IW +: IW] = up_q.pop_front();
            part++;
            if (part == R) begin
               exp_q.push_back(w_m);
               w_m  = '0;
               part = 0;
            end
         end else if (fl_act && (exp_q.size() == 0 || out_full_n)) begin
            exp_q.push_back(w_m);
            w_m  = '0;
            part = 0;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            chk("words_out", words_out, n_wr);
            if (out_write) begin
               if (exp_q.size() == 0) chk("spurious_write", out_write, 1'b0);
               else chk("out_din", out_din, exp_q.pop_front());
               n_wr++;
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input int max);
      int n = 0;
      while ((up_q.size() != 0 || exp_q.size() != 0) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", (up_q.size() == 0 && exp_q.size() == 0), 1'b1);
      cycles(2);
   endtask

   task automatic do_reset(input bit mid);
      if (mid) begin
         @(negedge clk);
         #3;
      end
      rst = 1'b1;
      #1;
      chk("rst_in_read", in_read, 1'b0);
      chk("rst_out_write", out_write, 1'b0);
      up_q.delete();
      exp_q.delete();
      w_m  = '0;
      part = 0;
      n_wr = '0;
      @(negedge clk);
      #3;
      chk("rst_out_din", out_din, '0);
      chk("rst_words_out", words_out, 16'd0);
      rst = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      do_reset(1'b0);

      // Eight ordered tokens give two words.
      for (int i = 1; i <= 8; i++) up_q.push_back(IW'(i));
      wait_drain(40);
      #3 chk("t1_words", words_out, 16'd2);

      // Streaming: one token per cycle, ten more words.
      for (int i = 0; i < 40; i++) up_q.push_back(IW'($urandom));
      wait_drain(60);
      #3 chk("t2_words", words_out, 16'd12);

      // Downstream full: three lanes fill, then the completing token stalls.
      p_full = 0;
      for (int i = 1; i <= 12; i++) up_q.push_back(IW'(i));
      cycles(15);
      #3;
      chk("t3_stall_ob", out_din, 32'h04030201);
      chk("t3_stall_left", up_q.size(), 5);
      cycles(5);
      #3 chk("t3_stall_hold", out_din, 32'h04030201);
      p_full = 100;
      wait_drain(40);
      #3 chk("t3_words", words_out, 16'd15);

      // Upstream empty mid-word: nothing written until the word completes.
      up_q.push_back(8'hAA);
      up_q.push_back(8'hBB);
      cycles(22);
      #3 chk("t4_gap_words", words_out, 16'd15);
      up_q.push_back(8'hCC);
      up_q.push_back(8'hDD);
      cycles(3);
      #3 chk("t4_word", out_din, 32'hDDCCBBAA);
      wait_drain(20);
      #3 chk("t4_words", words_out, 16'd16);

      // Asynchronous reset with a pending word and three lanes filled.
      p_full = 0;
      for (int i = 1; i <= 8; i++) up_q.push_back(IW'(i));
      cycles(12);
      p_full = 100;
      do_reset(1'b1);
      for (int i = 8'h11; i <= 8'h14; i++) up_q.push_back(IW'(i));
      cycles(6);
      #3 chk("t5_word", out_din, 32'h14131211);
      wait_drain(20);
      #3 chk("t5_words", words_out, 16'd1);

`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
      begin
         int n;
         up_q.push_back(8'h21);
         up_q.push_back(8'h22);
         cycles(6);
         @(negedge clk);
         flush = 1'b1;
         n = 0;
         while (part != 0 && n < 10) begin
            @(negedge clk);
            n++;
         end
         flush = 1'b0;
         chk("t6_flush_done", (part == 0), 1'b1);
         cycles(2);
         #3 chk("t6_flush_word", out_din, 32'h00002221);
         wait_drain(20);
         #3 chk("t6_words", words_out, 16'd2);
         @(negedge clk);
         flush = 1'b1;
         cycles(6);
         flush = 1'b0;
         cycles(2);
         #3 chk("t6_noop_words", words_out, 16'd2);
      end
`endif

      // Random availability and backpressure.
      for (int ph = 0; ph < 8; ph++) begin
         p_avail = int'($urandom_range(100, 20));
         p_full  = int'($urandom_range(100, 10));
         for (int i = 0; i < 48; i++) up_q.push_back(IW'($urandom));
         cycles(60);
      end
      p_avail = 100;
      p_full  = 100;
      wait_drain(400);
      chk("final_exp_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
